// File: rtl/lsb_mem_sched_pkg.sv
// Shared opcode codes, IO-region marker and scheduler state encoding for lsb_mem_sched.
package lsb_mem_sched_pkg;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  // addr[17:16] value selecting the memory-mapped IO window 0x30000-0x3FFFF
  localparam logic [1:0] IO_HI_DEF = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IO = 3'd1,
    BUSY    = 3'd2,
    DRAIN   = 3'd3,
    GAP     = 3'd4
  } state_e;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsb_mem_sched.sv
// Issues one LSB load/store at a time to the memory controller data port,
// with IO-store back-pressure, flush draining and a mandatory request gap.
module lsb_mem_sched
  import lsb_mem_sched_pkg::*;
#(
  parameter int         ROB_W = 4,
  parameter logic [1:0] IO_HI = IO_HI_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             req_valid,
  input  logic             req_is_head,
  input  logic [5:0]       req_opcode,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_data,
  input  logic [ROB_W-1:0] req_rob_id,
  output logic             req_ready,
  output logic             dat_sgn,
  output logic [31:0]      dat_addr,
  output logic [31:0]      dat_val,
  output logic [5:0]       dat_opcode,
  input  logic             dat_done,
  input  logic [31:0]      dat_rdata,
  input  logic             io_buffer_full,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_id,
  output logic [31:0]      cdb_val
);

  state_e             state_q, state_d;
  logic               sgn_q, sgn_d;
  logic               ready_q, ready_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        val_q, val_d;
  logic [5:0]         op_q, op_d;
  logic               load_q, load_d;
  logic [ROB_W-1:0]   rob_q, rob_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0]   cdb_rob_q, cdb_rob_d;
  logic [31:0]        cdb_val_q, cdb_val_d;

  logic req_store;
  logic req_io;
  logic legal;
  logic issue;

  assign req_store = is_store(req_opcode);
  assign req_io    = (req_addr[17:16] == IO_HI);
  // Stores must be committed; IO loads have side effects so must not be speculative.
  assign legal     = (req_store || req_io) ? req_is_head : 1'b1;

  always_comb begin
    state_d     = state_q;
    sgn_d       = sgn_q;
    ready_d     = 1'b0;
    addr_d      = addr_q;
    val_d       = val_q;
    op_d        = op_q;
    load_d      = load_q;
    rob_d       = rob_q;
    cdb_valid_d = 1'b0;
    cdb_rob_d   = cdb_rob_q;
    cdb_val_d   = cdb_val_q;
    issue       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && !clr && legal) begin
          if (req_store && req_io && io_buffer_full) state_d = WAIT_IO;
          else                                       issue   = 1'b1;
        end
      end
      WAIT_IO: begin
        if (!io_buffer_full) issue = 1'b1;
      end
      BUSY: begin
        if (dat_done) begin
          sgn_d   = 1'b0;
          state_d = GAP;
          if (load_q && !clr) begin
            cdb_valid_d = 1'b1;
            cdb_rob_d   = rob_q;
            cdb_val_d   = dat_rdata;
          end
        end else if (clr && load_q) begin
          // The controller cannot abort mid-access; keep requesting and drop the data.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dat_done) begin
          sgn_d   = 1'b0;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d = BUSY;
      sgn_d   = 1'b1;
      ready_d = 1'b1;
      addr_d  = req_addr;
      val_d   = req_data;
      op_d    = req_opcode;
      load_d  = !req_store;
      rob_d   = req_rob_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sgn_q       <= 1'b0;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      val_q       <= '0;
      op_q        <= '0;
      load_q      <= 1'b0;
      rob_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_val_q   <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      sgn_q       <= sgn_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      val_q       <= val_d;
      op_q        <= op_d;
      load_q      <= load_d;
      rob_q       <= rob_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_val_q   <= cdb_val_d;
    end
  end

  assign req_ready  = ready_q;
  assign dat_sgn    = sgn_q;
  assign dat_addr   = addr_q;
  assign dat_val    = val_q;
  assign dat_opcode = op_q;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_rob_id = cdb_rob_q;
  assign cdb_val    = cdb_val_q;

endmodule

// File: tb/tb_lsb_mem_sched.sv
// Directed plus randomized transaction bench for lsb_mem_sched against a
// transaction-level expectation model.
module tb_lsb_mem_sched;
  import lsb_mem_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        req_valid, req_is_head;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_rob_id;
  logic        req_ready, dat_sgn;
  logic [31:0] dat_addr, dat_val;
  logic [5:0]  dat_opcode;
  logic        dat_done;
  logic [31:0] dat_rdata;
  logic        io_buffer_full;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_val;

  int tests = 0;
  int fails = 0;

  lsb_mem_sched #(.ROB_W(4), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .req_valid(req_valid), .req_is_head(req_is_head), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_data(req_data), .req_rob_id(req_rob_id),
    .req_ready(req_ready), .dat_sgn(dat_sgn), .dat_addr(dat_addr),
    .dat_val(dat_val), .dat_opcode(dat_opcode), .dat_done(dat_done),
    .dat_rdata(dat_rdata), .io_buffer_full(io_buffer_full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_store(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  // One full transaction from presentation to the end of its gap cycle.
  task automatic txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] rob, input bit head, input int full_cyc,
                     input int lat, input int clr_mode, input logic [31:0] rdata);
    bit st, io, killed, exp_cdb;
    st = m_store(op);
    io = (addr[17:16] == 2'b11);
    killed = 0;
    req_valid = 1; req_opcode = op; req_addr = addr; req_data = data; req_rob_id = rob;
    req_is_head = head; io_buffer_full = (full_cyc > 0); clr = 0;
    if (!head && (st || io)) begin
      repeat (3) begin
        tick();
        chk("spec_hold_ready", 32'(req_ready), 32'd0);
        chk("spec_hold_sgn", 32'(dat_sgn), 32'd0);
      end
      req_is_head = 1;
    end
    if (st && io && full_cyc > 0) begin
      for (int k = 0; k < full_cyc; k++) begin
        tick();
        chk("iofull_ready", 32'(req_ready), 32'd0);
        chk("iofull_sgn", 32'(dat_sgn), 32'd0);
        clr = 1'($urandom_range(0, 1));
      end
      io_buffer_full = 0;
    end
    tick();
    chk("issue_ready", 32'(req_ready), 32'd1);
    chk("issue_sgn", 32'(dat_sgn), 32'd1);
    chk("issue_addr", dat_addr, addr);
    chk("issue_val", dat_val, data);
    chk("issue_op", 32'(dat_opcode), 32'(op));
    req_valid = 0; clr = 0; req_addr = $urandom; req_data = $urandom;
    io_buffer_full = 1'($urandom_range(0, 1));
    for (int i = 0; i < lat; i++) begin
      clr = (clr_mode == 1 && i == 0);
      if (clr && !st) killed = 1;
      tick();
      chk("busy_sgn", 32'(dat_sgn), 32'd1);
      chk("busy_ready", 32'(req_ready), 32'd0);
      chk("busy_addr", dat_addr, addr);
    end
    clr = 0;
    dat_done = 1; dat_rdata = rdata;
    if (clr_mode == 2) begin
      clr = 1;
      if (!st) killed = 1;
    end
    tick();
    dat_done = 0; clr = 0; dat_rdata = $urandom;
    exp_cdb = !st && !killed;
    chk("done_sgn", 32'(dat_sgn), 32'd0);
    chk("done_cdb_valid", 32'(cdb_valid), 32'(exp_cdb));
    if (exp_cdb) begin
      chk("done_cdb_val", cdb_val, rdata);
      chk("done_cdb_rob", 32'(cdb_rob_id), 32'(rob));
    end
    tick();
    chk("gap_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("gap_sgn", 32'(dat_sgn), 32'd0);
    io_buffer_full = 0;
    $display("[TB] txn op=%0d addr=%h head=%0d full=%0d lat=%0d clr=%0d cdb=%0d",
             op, addr, head, full_cyc, lat, clr_mode, exp_cdb);
  endtask

  logic [5:0] ops [8];
  logic [5:0] op;
  logic [31:0] a;

  initial begin
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    rst = 1; rdy = 1; clr = 0; req_valid = 0; req_is_head = 0; req_opcode = 0;
    req_addr = 0; req_data = 0; req_rob_id = 0; dat_done = 0; dat_rdata = 0;
    io_buffer_full = 0;
    tick(); tick();
    chk("rst_sgn", 32'(dat_sgn), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_addr", dat_addr, 32'd0);
    chk("rst_val", dat_val, 32'd0);
    chk("rst_op", 32'(dat_opcode), 32'd0);
    chk("rst_cdb_val", cdb_val, 32'd0);
    chk("rst_cdb_rob", 32'(cdb_rob_id), 32'd0);
    rst = 0;

    // Directed cases from the plan
    txn(OP_LW, 32'h1000, 32'h0, 4'd3, 0, 0, 2, 0, 32'hDEADBEEF);
    txn(OP_SB, 32'h30000, 32'h55, 4'd4, 1, 5, 1, 0, 32'h0);
    txn(OP_LB, 32'h30000, 32'h0, 4'd5, 0, 0, 1, 0, 32'h12);
    txn(OP_LW, 32'h1100, 32'h0, 4'd6, 0, 0, 3, 1, 32'hCAFEF00D);
    txn(OP_LW, 32'h1200, 32'h0, 4'd7, 0, 0, 1, 2, 32'hABCD0123);
    txn(OP_SW, 32'h1300, 32'h77, 4'd8, 1, 2, 2, 1, 32'h0);

    // Back-to-back SW 0x2000 then LW 0x2004: next request present during the gap
    req_valid = 1; req_is_head = 1; req_opcode = OP_SW; req_addr = 32'h2000;
    req_data = 32'h11223344; req_rob_id = 4'd9;
    tick();
    chk("b2b_first_ready", 32'(req_ready), 32'd1);
    req_is_head = 0; req_opcode = OP_LW; req_addr = 32'h2004; req_rob_id = 4'd10;
    tick();
    dat_done = 1; dat_rdata = 32'h0;
    tick();
    dat_done = 0;
    chk("b2b_gap0_sgn", 32'(dat_sgn), 32'd0);
    chk("b2b_gap0_cdb", 32'(cdb_valid), 32'd0);
    tick();
    chk("b2b_gap1_sgn", 32'(dat_sgn), 32'd0);
    chk("b2b_gap1_ready", 32'(req_ready), 32'd0);
    tick();
    chk("b2b_rise_sgn", 32'(dat_sgn), 32'd1);
    chk("b2b_rise_addr", dat_addr, 32'h2004);
    req_valid = 0;
    dat_done = 1; dat_rdata = 32'h600DD00D;
    tick();
    dat_done = 0;
    chk("b2b_cdb_valid", 32'(cdb_valid), 32'd1);
    chk("b2b_cdb_val", cdb_val, 32'h600DD00D);
    chk("b2b_cdb_rob", 32'(cdb_rob_id), 32'd10);
    tick();
    $display("[TB] txn back-to-back SW 0x2000 / LW 0x2004");

    // clr together with req_valid in IDLE blocks the issue
    req_valid = 1; req_is_head = 0; req_opcode = OP_LW; req_addr = 32'h4000; req_rob_id = 4'd2;
    clr = 1;
    tick();
    chk("clr_idle_ready", 32'(req_ready), 32'd0);
    chk("clr_idle_sgn", 32'(dat_sgn), 32'd0);
    clr = 0;
    tick();
    chk("clr_idle_then_issue", 32'(req_ready), 32'd1);
    req_valid = 0;

    // Reset mid-BUSY
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_busy_sgn", 32'(dat_sgn), 32'd0);
    chk("rst_busy_addr", dat_addr, 32'd0);
    tick();
    chk("rst_busy_idle", 32'(dat_sgn), 32'd0);
    $display("[TB] txn reset during BUSY");

    // rdy low freezes everything in BUSY, even with dat_done asserted
    req_valid = 1; req_opcode = OP_LHU; req_addr = 32'h5000; req_rob_id = 4'd11;
    tick();
    req_valid = 0;
    tick();
    rdy = 0; dat_done = 1; dat_rdata = 32'h0BADCAFE;
    repeat (3) begin
      tick();
      chk("rdy_sgn", 32'(dat_sgn), 32'd1);
      chk("rdy_addr", dat_addr, 32'h5000);
      chk("rdy_cdb", 32'(cdb_valid), 32'd0);
    end
    rdy = 1;
    tick();
    dat_done = 0;
    chk("rdy_done_sgn", 32'(dat_sgn), 32'd0);
    chk("rdy_done_cdb", 32'(cdb_valid), 32'd1);
    chk("rdy_done_val", cdb_val, 32'h0BADCAFE);
    tick();
    $display("[TB] txn rdy freeze in BUSY");

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[17:16] = 2'b11;
      txn(op, a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 2), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
